// File: rtl/test_stream_checker_if.sv
// Word stream into the memfifo test-data checker: 16-bit words, two bytes each,
// low byte first in stream order.
interface test_stream_checker_if;
   // A word transfers on a rising clock edge where DI_valid and DI_ready are
   // both high. DI is held stable while DI_valid waits for DI_ready.
   logic [15:0] DI;
   logic        DI_valid;
   logic        DI_ready;

   modport master (
      output DI,
      output DI_valid,
      input  DI_ready
   );

   modport slave (
      input  DI,
      input  DI_valid,
      output DI_ready
   );
endinterface

// File: rtl/test_stream_checker.sv
// Receive-side checker for the memfifo test data generator: finds 16-byte block
// alignment, checks sync bits, counter sequence and checksum, and counts results.
module test_stream_checker #(
   parameter int LOSS_THRESHOLD = 4,
   parameter int ERR_W          = 16
) (
   input  logic                   ifclk,
   input  logic                   reset,
   input  logic                   enable,
   test_stream_checker_if.slave   din,
   output logic                   locked,
   output logic                   block_ok,
   output logic                   block_err,
   output logic [31:0]            good_blocks,
   output logic [ERR_W-1:0]       errors,
   output logic [3:0]             status
);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic [13:0]      CS_INIT  = 14'd47;
   localparam logic [6:0]       VAL_STEP = 7'd111;
   localparam logic [3:0]       LOSS_T   = 4'(LOSS_THRESHOLD);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

   logic [1:0]  state;
   logic [2:0]  word_idx;
   logic [13:0] cs;
   logic [6:0]  exp_val;     // expected b0 val of the next block
   logic [6:0]  prev_val;    // val of the previous odd byte in this block
   logic        need_seed;   // next b0 val seeds the counter instead of being checked
   logic        blk_fail;
   logic [3:0]  bad_run;
   logic        rst_d;
   logic        rdy_q;

   logic [7:0]  lo_byte;
   logic [7:0]  hi_byte;
   logic        consume;
   logic        last_word;
   logic        sync_bad;
   logic [6:0]  lo_exp;
   logic        lo_bad;
   logic [13:0] cs_lo;
   logic [13:0] cs_next;
   logic [6:0]  fold;
   logic [6:0]  hi_exp;
   logic        hi_bad;
   logic        blk_bad;
   logic [3:0]  bad_run_inc;
   logic        run_lost;

   assign din.DI_ready = rdy_q;
   assign locked       = (state == ST_LOCKED);
   assign status       = {bad_run[1:0], state};

   always_comb begin
      lo_byte     = din.DI[7:0];
      hi_byte     = din.DI[15:8];
      consume     = din.DI_valid && rdy_q && enable;
      last_word   = (word_idx == 3'd7);
      // Even bytes carry sync 0 except b14; every odd byte carries sync 1.
      sync_bad    = (lo_byte[7] != last_word) || !hi_byte[7];
      lo_exp      = (word_idx == 3'd0) ? exp_val : prev_val + VAL_STEP;
      lo_bad      = !((word_idx == 3'd0) && need_seed) && (lo_byte[6:0] != lo_exp);
      cs_lo       = cs + {6'd0, lo_byte};
      cs_next     = cs_lo + {6'd0, hi_byte};
      // At word 7 the low byte is b14, the last byte covered by the checksum.
      fold        = cs_lo[6:0] ^ cs_lo[13:7];
      hi_exp      = last_word ? fold : lo_byte[6:0] + VAL_STEP;
      hi_bad      = (hi_byte[6:0] != hi_exp);
      blk_bad     = blk_fail || sync_bad || lo_bad || hi_bad;
      bad_run_inc = bad_run + 4'd1;
      run_lost    = (bad_run_inc == LOSS_T);
   end

   always_ff @(posedge ifclk) begin
      rst_d <= reset;
      if (reset) begin
         rdy_q       <= 1'b0;
         state       <= ST_HUNT;
         word_idx    <= 3'd0;
         cs          <= CS_INIT;
         exp_val     <= 7'd0;
         prev_val    <= 7'd0;
         need_seed   <= 1'b1;
         blk_fail    <= 1'b0;
         bad_run     <= 4'd0;
         block_ok    <= 1'b0;
         block_err   <= 1'b0;
         good_blocks <= 32'd0;
         errors      <= '0;
      end else begin
         // Ready stays low for one extra cycle after reset is released.
         rdy_q     <= !rst_d;
         block_ok  <= 1'b0;
         block_err <= 1'b0;
         if (consume) begin
            case (state)
               ST_HUNT: begin
                  if (lo_byte[7] && hi_byte[7]) begin
                     state     <= ST_VERIFY;
                     word_idx  <= 3'd0;
                     cs        <= CS_INIT;
                     need_seed <= 1'b1;
                     blk_fail  <= 1'b0;
                  end
               end
               ST_VERIFY, ST_LOCKED: begin
                  prev_val <= hi_byte[6:0];
                  if (!last_word) begin
                     word_idx  <= word_idx + 3'd1;
                     cs        <= cs_next;
                     blk_fail  <= blk_bad;
                     need_seed <= 1'b0;
                  end else begin
                     word_idx <= 3'd0;
                     cs       <= CS_INIT;
                     blk_fail <= 1'b0;
                     exp_val  <= lo_byte[6:0] + VAL_STEP;
                     if (blk_bad) begin
                        block_err <= 1'b1;
                        if (errors != ERR_MAX)
                           errors <= errors + ERR_ONE;
                        if (state == ST_VERIFY) begin
                           state <= ST_HUNT;
                        end else if (run_lost) begin
                           state   <= ST_HUNT;
                           bad_run <= 4'd0;
                        end else begin
                           bad_run   <= bad_run_inc;
                           need_seed <= 1'b1;
                        end
                     end else begin
                        block_ok    <= 1'b1;
                        good_blocks <= good_blocks + 32'd1;
                        bad_run     <= 4'd0;
                        need_seed   <= 1'b0;
                        state       <= ST_LOCKED;
                     end
                  end
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

endmodule

// File: doc/test_stream_checker.md
Name: test_stream_checker

Overview:
- Receive-side counterpart of the memfifo test data generator.
- Consumes the 16-bit word stream produced by that generator, as read back from the DRAM FIFO or looped back through EZ-USB, on the ifclk domain.
- Finds block alignment, checks every 16-byte block (sync bits, counter sequence, checksum), and reports lock state, good-block and error counts, and per-block pulses for LEDs/GPIO.

Parameters:
- LOSS_THRESHOLD, 4: consecutive bad blocks in LOCKED that force re-hunt (1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- ifclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  0 = ignore input, hold state and counters.
- DI  in  16  data word; low byte is the earlier byte in the stream.
- DI_valid  in  1  DI carries a word this cycle.
- DI_ready  out  1  registered; 0 during reset and the cycle after, else 1.
- locked  out  1  state == LOCKED.
- block_ok  out  1  one-cycle pulse per block passing all checks.
- block_err  out  1  one-cycle pulse per failing block (VERIFY or LOCKED).
- good_blocks  out  32  wrapping count of block_ok pulses.
- errors  out  ERR_W  saturating count of block_err pulses.
- status  out  4  {bad_run[1:0], state[1:0]}; HUNT=0, VERIFY=1, LOCKED=2.

Behaviour:
- Reset values: DI_ready=0, locked=0, block_ok=0, block_err=0, good_blocks=0, errors=0, status=0, state=HUNT, word_idx=0, bad_run=0, cs=47.
- A word is consumed only when DI_valid && DI_ready && enable.
- Block format, bytes b0..b15, b = {sync, val[6:0]}:
  - Sync bits for b0..b15 are 0,1,0,1,0,1,0,1,0,1,0,1,0,1,1,1.
  - For b0..b14, val(k+1) = val(k) + 111 mod 128. b0 of each block = b14 of the previous block + 111 mod 128.
  - Checksum: cs = 47 + sum of the 8-bit values b0..b14, mod 2^14.
  - b15 val must equal cs[6:0] ^ cs[13:7].
- Word w (0..7) = {b(2w+1), b(2w)}.
- HUNT:
  - On each consumed word, if DI[7] && DI[15], go to VERIFY with word_idx=0 and cs=47.
  - Otherwise stay in HUNT. No counters change.
- VERIFY and LOCKED, per consumed word:
  - Check the sync bits against the table for word_idx.
  - At word_idx 0 in VERIFY, or in LOCKED after a bad block, b0 val seeds the counter expectation and is not checked. Otherwise b0 val must equal the expectation.
  - Within the block, each byte val must equal the previous val + 111 mod 128.
  - Accumulate cs over b0..b14.
  - At word_idx 7, compare b15 with the fold. The block-fail flag is the OR of all mismatches in the block.
  - word_idx wraps 7 -> 0. cs resets to 47 at the block boundary.
- Result at end of block (registered; pulse appears the cycle after the word-7 edge, latency 1):
  - VERIFY pass: block_ok, good_blocks+1, go to LOCKED, bad_run=0.
  - VERIFY fail: block_err, errors+1, go to HUNT.
  - LOCKED pass: block_ok, good_blocks+1, bad_run=0.
  - LOCKED fail: block_err, errors+1, bad_run+1, re-seed the expectation at the next b0. When bad_run reaches LOSS_THRESHOLD, go to HUNT and clear bad_run.
- errors saturates at all-ones. good_blocks wraps modulo 2^32.
- status bad_run field shows bad_run[1:0].
- enable=0 mid-block: partial block state is frozen; checking resumes on re-enable.
- reset mid-block: everything returns to reset values. No pulse is emitted for the partial block.
- Gaps in DI_valid at any word position are allowed and do not affect the result.

Test Plan:
- Reset, then stream generator blocks starting at cnt=0. Block 0 words: EF00, CD5E, AB3C, 891A, E778, C556, A334, B992. Next block starts b0=0x01. Required: block 0 consumed in HUNT (word B992 triggers VERIFY); block 1 gives block_ok and locked=1; block 2 gives good_blocks=2; errors=0.
- Locked stream, block 5 checksum byte flipped (B992-style word with hi byte ^0x01). Required: one block_err, errors=1, bad_run=1. Next good block gives block_ok, bad_run=0, locked stays 1.
- Locked stream, one word dropped. Required: 4 consecutive block_err, then state=HUNT, locked=0. After the next word with both sync bits set, one VERIFY block, then LOCKED again with errors=4.
- Random DI_valid gaps (50% duty) on a clean stream of 100 blocks. Required: good_blocks=99 (first block used for hunt), errors=0.
- Force errors past 2^ERR_W-1 with ERR_W=4 and LOSS_THRESHOLD=15. Required: errors sticks at 15.
- Assert reset at word_idx 4 of a LOCKED block. Required: all outputs at reset values, DI_ready=0 for 2 cycles, no pulse emitted, re-hunt on the resumed stream.
